// File: rtl/button_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : button_conditioner
// Purpose  : Conditions two raw push-button inputs (start and user) for the
//            reaction-time benchmark core. Each channel runs a 2-FF
//            synchroniser, then a counter-based debouncer, then a rising-edge
//            detector. The result is a registered one-cycle trigger and a
//            debounced level. The two channels are identical and independent.
// Ports    : clk            - system clock (single domain)
//            rst            - synchronous, active-high reset
//            start_btn_raw  - raw start button (async, active-high, bouncy)
//            user_btn_raw   - raw user button (async, active-high, bouncy)
//            start_trigger  - one-cycle pulse on a debounced start press
//            user_trigger   - one-cycle pulse on a debounced user press
//            start_level    - debounced start level
//            user_level     - debounced user level
// Options  : TRIGGER_LOCKOUT_EN - when defined and both channels would pulse
//            in the same cycle, only user_trigger asserts. The start pulse
//            for that event is dropped and is not issued later.
// Revision : 1.0 - initial release
// ============================================================================
module button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 500,
    parameter int CNT_W           = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic start_btn_raw,
    input  logic user_btn_raw,
    output logic start_trigger,
    output logic user_trigger,
    output logic start_level,
    output logic user_level
);

    // Terminal count. A changed level must persist this many cycles plus one
    // before it is accepted.
    localparam logic [CNT_W-1:0] c_cnt_max = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Channel index 0 = start, 1 = user
    logic [1:0] w_raw;
    logic [1:0] w_level;
    logic [1:0] w_rise;
    logic [1:0] w_trig_next;
    logic [1:0] r_trig;

    assign w_raw = {user_btn_raw, start_btn_raw};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_chan
            logic             r_sync1;
            logic             r_sync2;
            logic             r_stable;
            logic [CNT_W-1:0] r_cnt;
            logic             w_done;

            // The synchronised level differs from the accepted level and has
            // done so long enough. The accepted level flips on this edge.
            assign w_done = (r_sync2 != r_stable) && (r_cnt == c_cnt_max);

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_sync1  <= 1'b0;
                    r_sync2  <= 1'b0;
                    r_stable <= 1'b0;
                    r_cnt    <= '0;
                end else begin
                    r_sync1 <= w_raw[gi];
                    r_sync2 <= r_sync1;
                    if (r_sync2 == r_stable) begin
                        // A bounce back to the accepted level restarts the count
                        r_cnt <= '0;
                    end else if (w_done) begin
                        r_stable <= r_sync2;
                        r_cnt    <= '0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
            end

            assign w_level[gi] = r_stable;
            // A press is accepted on exactly the edge where r_stable goes 0->1
            assign w_rise[gi]  = w_done & r_sync2;
        end
    endgenerate

`ifdef TRIGGER_LOCKOUT_EN
    // The user pulse wins a same-cycle collision so the benchmark never sees
    // a start and a reaction together.
    assign w_trig_next = {w_rise[1], w_rise[0] & ~w_rise[1]};
`else
    assign w_trig_next = w_rise;
`endif

    // The trigger is registered on the same edge that updates the level, so
    // level and trigger rise together.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_trig <= 2'b00;
        end else begin
            r_trig <= w_trig_next;
        end
    end

    assign start_trigger = r_trig[0];
    assign user_trigger  = r_trig[1];
    assign start_level   = w_level[0];
    assign user_level    = w_level[1];

endmodule
`default_nettype wire

// File: tb/tb_button_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : tb_button_conditioner
// Purpose  : Self-checking bench for button_conditioner with
//            DEBOUNCE_CYCLES=4 and CNT_W=2, so the terminal count is the
//            largest value the counter can hold. Stimulus pushes the expected
//            trigger events (cycle stamp plus which triggers) into a queue.
//            A monitor pops an entry each time a trigger is seen and compares
//            it. Debounced levels are checked directly at chosen points.
// Revision : 1.0 - initial release
// ============================================================================
module tb_button_conditioner;

    localparam int c_DEB = 4;
    // Number of posedges from driving a raw input to seeing level/trigger
    localparam int c_LAT = c_DEB + 2;

    logic clk;
    logic rst;
    logic start_btn_raw;
    logic user_btn_raw;
    logic start_trigger;
    logic user_trigger;
    logic start_level;
    logic user_level;

    typedef struct {
        int   cyc;
        logic st;
        logic us;
    } trig_ev_t;

    trig_ev_t exp_q[$];
    int       cyc;
    int       total;
    int       bad;

    button_conditioner #(
        .DEBOUNCE_CYCLES (c_DEB),
        .CNT_W           (2)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start_btn_raw (start_btn_raw),
        .user_btn_raw  (user_btn_raw),
        .start_trigger (start_trigger),
        .user_trigger  (user_trigger),
        .start_level   (start_level),
        .user_level    (user_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // cyc holds the number of posedges seen so far
    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int at, input logic st, input logic us);
        trig_ev_t e;
        e.cyc = at;
        e.st  = st;
        e.us  = us;
        exp_q.push_back(e);
    endtask

    // Trigger monitor: outputs are sampled on the falling edge
    always @(negedge clk) begin
        if (start_trigger === 1'b1 || user_trigger === 1'b1) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL trig_unexpected: got start=%b user=%b at cycle %0d, expected none",
                         start_trigger, user_trigger, cyc);
            end else begin
                trig_ev_t e;
                e = exp_q.pop_front();
                if (e.cyc != cyc || e.st !== start_trigger || e.us !== user_trigger) begin
                    bad++;
                    $display("FAIL trig_event: got start=%b user=%b at cycle %0d, expected start=%b user=%b at cycle %0d",
                             start_trigger, user_trigger, cyc, e.st, e.us, e.cyc);
                end
            end
        end
    end

    initial begin
        int c;
        total         = 0;
        bad           = 0;
        rst           = 1'b1;
        start_btn_raw = 1'b0;
        user_btn_raw  = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_start_level", start_level, 1'b0);
        chk("rst_user_level", user_level, 1'b0);
        chk("rst_start_trigger", start_trigger, 1'b0);
        chk("rst_user_trigger", user_trigger, 1'b0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Clean start press: one pulse, level held, user untouched
        c = cyc;
        start_btn_raw = 1'b1;
        push(c + c_LAT, 1'b1, 1'b0);
        repeat (c_LAT - 1) @(negedge clk);
        chk("start_level_early", start_level, 1'b0);
        repeat (20 - (c_LAT - 1)) @(negedge clk);
        chk("start_level_held", start_level, 1'b1);
        chk("user_level_idle", user_level, 1'b0);
        start_btn_raw = 1'b0;
        repeat (10) @(negedge clk);
        chk("start_level_released", start_level, 1'b0);

        // Bouncing user press: 1,0,1,0,... for 10 cycles, then held
        for (int k = 0; k < 10; k++) begin
            user_btn_raw = (k % 2 == 0) ? 1'b1 : 1'b0;
            @(negedge clk);
        end
        chk("user_level_bounce", user_level, 1'b0);
        c = cyc;
        user_btn_raw = 1'b1;
        push(c + c_LAT, 1'b0, 1'b1);
        repeat (12) @(negedge clk);
        chk("user_level_held", user_level, 1'b1);
        user_btn_raw = 1'b0;
        repeat (10) @(negedge clk);
        chk("user_level_released", user_level, 1'b0);

        // Glitch one cycle shorter than the debounce window
        user_btn_raw = 1'b1;
        repeat (3) @(negedge clk);
        user_btn_raw = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (user_level !== 1'b0)
                chk("user_level_glitch", user_level, 1'b0);
        end
        chk("user_level_after_glitch", user_level, 1'b0);

        // Start held through a reset taken before the debounce completes
        start_btn_raw = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_mid_start_level", start_level, 1'b0);
        chk("rst_mid_start_trigger", start_trigger, 1'b0);
        c = cyc;
        push(c + c_LAT, 1'b1, 1'b0);
        repeat (12) @(negedge clk);
        chk("start_level_after_rst", start_level, 1'b1);
        start_btn_raw = 1'b0;
        repeat (10) @(negedge clk);

        // Simultaneous presses
        c = cyc;
        start_btn_raw = 1'b1;
        user_btn_raw  = 1'b1;
`ifdef TRIGGER_LOCKOUT_EN
        push(c + c_LAT, 1'b0, 1'b1);
`else
        push(c + c_LAT, 1'b1, 1'b1);
`endif
        repeat (12) @(negedge clk);
        chk("both_start_level", start_level, 1'b1);
        chk("both_user_level", user_level, 1'b1);
        start_btn_raw = 1'b0;
        user_btn_raw  = 1'b0;
        repeat (10) @(negedge clk);
        chk("both_start_released", start_level, 1'b0);
        chk("both_user_released", user_level, 1'b0);

        // Every expected trigger must have been observed
        while (exp_q.size() != 0) begin
            trig_ev_t e;
            e = exp_q.pop_front();
            total++;
            bad++;
            $display("FAIL trig_missing: got no trigger, expected start=%b user=%b at cycle %0d",
                     e.st, e.us, e.cyc);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
